// File: rtl/rsd_residue_reader.sv
// rtl/rsd_residue_reader.sv - converts WORDS redundant plus/minus residue words to two's complement
// Words are read LSW first; the borrow chain only advances on an accepted output word.
module rsd_residue_reader #(
   parameter int bits           = 4,
   parameter int RAM_ADDR_WIDTH = 7,
   parameter int WORDS          = 8
) (
   input  logic                      clk,
   input  logic                      asyn_reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
   output logic [RAM_ADDR_WIDTH-1:0] read_addr,
   output logic                      rd_en,
   input  logic [bits-1:0]           residue_plus,
   input  logic [bits-1:0]           residue_minus,
   output logic [bits-1:0]           out_word,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      done,
   output logic                      sign
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] CAP  = 3'd2;
   localparam logic [2:0] OUT  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [RAM_ADDR_WIDTH-1:0] LAST_INDEX = RAM_ADDR_WIDTH'(WORDS - 1);

   logic [2:0]                state;
   logic [RAM_ADDR_WIDTH-1:0] base;
   logic [RAM_ADDR_WIDTH-1:0] index;
   logic                      borrow;
   logic                      pending_borrow;
   logic [bits:0]             diff;

   // The top bit of the widened subtraction is the borrow out of this word.
   assign diff      = {1'b0, residue_plus} - {1'b0, residue_minus} - {{bits{1'b0}}, borrow};
   assign read_addr = base + index;
   assign rd_en     = (state == RD);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge asyn_reset_n) begin
      if (!asyn_reset_n) begin
         state          <= IDLE;
         base           <= '0;
         index          <= '0;
         borrow         <= 1'b0;
         pending_borrow <= 1'b0;
         out_word       <= '0;
         out_last       <= 1'b0;
         sign           <= 1'b0;
      end else if (abort && state != IDLE) begin
         state    <= IDLE;
         out_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base   <= base_addr;
                  index  <= '0;
                  borrow <= 1'b0;
                  sign   <= 1'b0;
                  state  <= RD;
               end
            end
            RD: state <= CAP;
            CAP: begin
               out_word       <= diff[bits-1:0];
               pending_borrow <= diff[bits];
               out_last       <= (index == LAST_INDEX);
               state          <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  borrow   <= pending_borrow;
                  out_last <= 1'b0;
                  if (out_last) begin
                     sign  <= pending_borrow;
                     state <= DONE;
                  end else begin
                     index <= index + 1'b1;
                     state <= RD;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rsd_residue_reader.sv
// tb/tb_rsd_residue_reader.sv - vector table, corner sequences and randomized model check
module tb_rsd_residue_reader;

   localparam int W = 2;
   typedef logic [3:0] nib_t;

   logic       clk;
   logic       asyn_reset_n;
   logic       start;
   logic       abort;
   logic [6:0] base_addr;
   logic [6:0] read_addr;
   logic       rd_en;
   nib_t       residue_plus;
   nib_t       residue_minus;
   nib_t       out_word;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       sign;

   int checks   = 0;
   int failures = 0;

   nib_t ram_p [0:127];
   nib_t ram_m [0:127];
   nib_t got_w [W];
   nib_t exp_w [W];
   logic got_sign;
   logic exp_s;

   typedef struct {
      logic [6:0] base;
      nib_t       p0, p1, m0, m1;
      nib_t       e0, e1;
      logic       es;
      int         mode;
      bit         glitch;
   } vec_t;
   vec_t vec [7];

   rsd_residue_reader #(.bits(4), .RAM_ADDR_WIDTH(7), .WORDS(W)) dut (
      .clk(clk), .asyn_reset_n(asyn_reset_n), .start(start), .abort(abort),
      .base_addr(base_addr), .read_addr(read_addr), .rd_en(rd_en),
      .residue_plus(residue_plus), .residue_minus(residue_minus),
      .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .sign(sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read RAM pair
   always @(posedge clk) begin
      if (rd_en) begin
         residue_plus  <= ram_p[read_addr];
         residue_minus <= ram_m[read_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [6:0] base, input nib_t p0, input nib_t p1, input nib_t m0, input nib_t m1);
      ram_p[base] = p0;
      ram_m[base] = m0;
      ram_p[7'(base + 1)] = p1;
      ram_m[7'(base + 1)] = m1;
   endtask

   // Reference: the residue value is sum((plus_i - minus_i) * 16^i); words are its 16^W residue.
   task automatic model(input logic [6:0] base);
      longint v = 0;
      longint pw = 1;
      for (int i = 0; i < W; i++) begin
         v += (longint'(ram_p[7'(base + i)]) - longint'(ram_m[7'(base + i)])) * pw;
         pw *= 16;
      end
      exp_s = (v < 0);
      if (v < 0) v += pw;
      for (int i = 0; i < W; i++) begin
         exp_w[i] = nib_t'(v % 16);
         v = v / 16;
      end
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check(name, out_valid, 1);
   endtask

   // mode 0: ready always, 1: random ready, 2: word 0 stalled 5 cycles
   task automatic conv(input logic [6:0] base, input int mode, input bit glitch);
      int   n = 0;
      int   cyc = 0;
      int   stall = 0;
      bit   fin = 0;
      bit   hold = 0;
      nib_t held_w = '0;
      logic [6:0] held_a = '0;
      @(negedge clk);
      base_addr = base;
      start     = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("rd_en_first_cycle", rd_en, 1);
      check("sign_cleared_on_start", sign, 0);
      while (!fin && cyc < 300) begin
         if (glitch && cyc == 1) begin
            start     = 1'b1;
            base_addr = base + 7'd50;
         end else begin
            start = 1'b0;
         end
         if (rd_en) check("read_addr", read_addr, 7'(base + n));
         if (done) begin
            fin = 1;
            check("words_before_done", n, W);
         end else if (out_valid) begin
            if (hold) begin
               check("stall_word", out_word, held_w);
               check("stall_addr", read_addr, held_a);
               check("stall_rd_en", rd_en, 0);
            end else if (mode == 0) begin
               check("valid_cycle", cyc, 2 + 3 * n);
            end
            check("out_last", out_last, (n == W - 1));
            case (mode)
               0:       out_ready = 1'b1;
               1:       out_ready = ($urandom_range(0, 2) != 0);
               default: out_ready = (n != 0 || stall >= 5);
            endcase
            if (out_ready) begin
               if (n < W) got_w[n] = out_word;
               n++;
               hold = 0;
            end else begin
               stall++;
               hold   = 1;
               held_w = out_word;
               held_a = read_addr;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", fin, 1);
      got_sign = sign;
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      asyn_reset_n = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      out_ready    = 1'b0;
      base_addr    = '0;
      for (int i = 0; i < 128; i++) begin
         ram_p[i] = '0;
         ram_m[i] = '0;
      end

      vec[0] = '{7'd0,   4'd3, 4'd5, 4'd1, 4'd2, 4'h2, 4'h3, 1'b0, 0, 1'b0};
      vec[1] = '{7'd10,  4'd0, 4'd4, 4'd1, 4'd0, 4'hF, 4'h3, 1'b0, 0, 1'b0};
      vec[2] = '{7'd20,  4'd0, 4'd0, 4'd1, 4'd0, 4'hF, 4'hF, 1'b1, 0, 1'b0};
      vec[3] = '{7'd0,   4'd3, 4'd5, 4'd1, 4'd2, 4'h2, 4'h3, 1'b0, 2, 1'b0};
      vec[4] = '{7'd30,  4'd9, 4'd2, 4'd4, 4'd1, 4'h5, 4'h1, 1'b0, 0, 1'b1};
      vec[5] = '{7'd127, 4'd7, 4'd1, 4'd2, 4'd1, 4'h5, 4'h0, 1'b0, 0, 1'b0};
      vec[6] = '{7'd50,  4'd8, 4'd7, 4'd9, 4'd7, 4'hF, 4'hF, 1'b1, 1, 1'b0};

      repeat (2) @(negedge clk);
      check("rst_read_addr", read_addr, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_out_word", out_word, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sign", sign, 0);
      asyn_reset_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load(vec[i].base, vec[i].p0, vec[i].p1, vec[i].m0, vec[i].m1);
         conv(vec[i].base, vec[i].mode, vec[i].glitch);
         check("vec_word0", got_w[0], vec[i].e0);
         check("vec_word1", got_w[1], vec[i].e1);
         check("vec_sign", got_sign, vec[i].es);
         repeat (3) @(negedge clk);
         check("sign_held_idle", sign, vec[i].es);
      end

      // Abort on the last word after a borrow has been taken from word 0
      load(7'd40, 4'd0, 4'd0, 4'd1, 4'd0);
      @(negedge clk);
      base_addr = 7'd40;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid("abort_word0_valid");
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      wait_valid("abort_word1_valid");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_rd_en", rd_en, 0);
      check("abort_out_last", out_last, 0);
      check("abort_sign", sign, 0);
      for (int k = 0; k < 5; k++) begin
         check("abort_no_done", done, 0);
         @(negedge clk);
      end
      load(vec[0].base, vec[0].p0, vec[0].p1, vec[0].m0, vec[0].m1);
      conv(vec[0].base, 0, 1'b0);
      check("post_abort_word0", got_w[0], 4'h2);
      check("post_abort_word1", got_w[1], 4'h3);

      // Reset asserted while in RD
      @(negedge clk);
      base_addr = 7'd5;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midrd_rd_en", rd_en, 1);
      asyn_reset_n = 1'b0;
      #1;
      check("midrd_rst_read_addr", read_addr, 0);
      check("midrd_rst_rd_en", rd_en, 0);
      check("midrd_rst_busy", busy, 0);
      check("midrd_rst_out_valid", out_valid, 0);
      check("midrd_rst_done", done, 0);
      @(negedge clk);
      asyn_reset_n = 1'b1;

      for (int r = 0; r < 40; r++) begin
         logic [6:0] b;
         b = 7'($urandom_range(0, 127));
         load(b, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
         model(b);
         conv(b, 1, 1'b0);
         check("rand_word0", got_w[0], exp_w[0]);
         check("rand_word1", got_w[1], exp_w[1]);
         check("rand_sign", got_sign, exp_s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
